// File: rtl/td4_run_ctrl.sv
// ---------------------------------------------------------------------------
// td4_run_ctrl
//
// Run-control unit for the TD4 CPU core. Gates the core clock enable to give
// free-run, single-step, address-breakpoint and cycle-limit halting, and
// counts the cycles in which the core was enabled.
//
// Parameters
//   ADDR_W      width of the program address used for breakpoints
//   CNT_W       width of the executed-cycle counter
//   MAX_CYCLES  cycle limit (0 = unlimited), must fit in CNT_W bits
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous reset, active-high
//   RUN       in   level, requests free-running execution
//   STEP      in   one-cycle pulse, requests one instruction
//   HALT_REQ  in   level, forces a stop to IDLE while high
//   BRK_EN    in   breakpoint enable
//   BRK_ADDR  in   breakpoint address
//   PC        in   core program address (td4 MEM_ADDR)
//   CPU_CE    out  clock enable to the core (combinational)
//   CPU_RST   out  reset to the core
//   CYCLES    out  number of cycles with CPU_CE=1 since reset (saturating)
//   STATE     out  IDLE=0, RUN=1, STEP=2, BREAK=3, DONE=4
//   DONE      out  high in the DONE state
// ---------------------------------------------------------------------------
module td4_run_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 200
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic              STEP,
    input  logic              HALT_REQ,
    input  logic              BRK_EN,
    input  logic [ADDR_W-1:0] BRK_ADDR,
    input  logic [ADDR_W-1:0] PC,
    output logic              CPU_CE,
    output logic              CPU_RST,
    output logic [CNT_W-1:0]  CYCLES,
    output logic [2:0]        STATE,
    output logic              DONE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_BREAK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CYCLES);
    localparam bit               LIMIT_ON = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cycles;
    logic             resume;
    logic             cpu_rst;
    logic             cpu_ce;
    logic             limit_hit;
    logic             brk_hit;
    logic             step_reaches_limit;

    // The resume flag masks the breakpoint for the first RUN cycle so that
    // restarting while sitting on BRK_ADDR executes that instruction once.
    assign limit_hit = LIMIT_ON && (cycles == LIMIT);
    assign brk_hit   = BRK_EN && (PC == BRK_ADDR) && !resume;

    // A step that performs the last permitted cycle goes straight to DONE
    // instead of passing back through IDLE.
    assign step_reaches_limit = LIMIT_ON && cpu_ce && ((cycles + CNT_W'(1)) == LIMIT);

    // Core clock enable: only RUN and STEP ever let the core advance, and a
    // breakpoint drops it in the very cycle PC reaches BRK_ADDR.
    always_comb begin
        cpu_ce = 1'b0;
        if (!cpu_rst) begin
            case (state)
                S_RUN:   cpu_ce = !limit_hit && !HALT_REQ && !brk_hit;
                S_STEP:  cpu_ce = !limit_hit;
                default: cpu_ce = 1'b0;
            endcase
        end
    end

    // Next-state logic; the if/else order in each state encodes the event
    // priority limit > halt > breakpoint > RUN release.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (limit_hit)
                    state_next = S_DONE;
                else if (RUN && !HALT_REQ)
                    state_next = S_RUN;
                else if (STEP && !HALT_REQ)
                    state_next = S_STEP;
            end
            S_RUN: begin
                if (limit_hit)
                    state_next = S_DONE;
                else if (HALT_REQ)
                    state_next = S_IDLE;
                else if (brk_hit)
                    state_next = S_BREAK;
                else if (!RUN)
                    state_next = S_IDLE;
            end
            S_STEP: begin
                if (limit_hit || step_reaches_limit)
                    state_next = S_DONE;
                else
                    state_next = S_IDLE;
            end
            S_BREAK: begin
                if (limit_hit)
                    state_next = S_DONE;
                else if (HALT_REQ)
                    state_next = S_IDLE;
                else if (STEP)
                    state_next = S_STEP;
                else if (!RUN)
                    state_next = S_IDLE;
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, saturating cycle counter, resume flag and the core reset, which
    // is held until the first clock edge after RST is released.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            cycles  <= '0;
            resume  <= 1'b0;
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= 1'b0;
            state   <= state_next;
            if (cpu_ce && (cycles != CNT_MAX))
                cycles <= cycles + CNT_W'(1);
            if (state == S_RUN)
                resume <= 1'b0;
            else if ((state == S_IDLE) && (state_next == S_RUN))
                resume <= 1'b1;
        end
    end

    assign CPU_CE  = cpu_ce;
    assign CPU_RST = cpu_rst;
    assign CYCLES  = cycles;
    assign STATE   = state;
    assign DONE    = (state == S_DONE);

endmodule

// File: tb/tb_td4_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_td4_run_ctrl
//
// Self-checking bench for td4_run_ctrl. DUT a uses the default parameters and
// drives a small core model (a 4-bit PC that advances on CPU_CE); DUT b is a
// 4-bit-counter, unlimited variant used for the saturation case.
// ---------------------------------------------------------------------------
module tb_td4_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run, step, halt_req, brk_en;
    logic [3:0] brk_addr;
    logic [3:0] pc_drv;
    logic       use_core;
    logic [3:0] core_pc;
    logic [3:0] pc_in;

    logic       cpu_ce, cpu_rst, done;
    logic [7:0] cycles;
    logic [2:0] state;

    logic       b_run;
    logic       b_ce, b_rst, b_done;
    logic [3:0] b_cycles;
    logic [2:0] b_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       run, step, halt, brk_en;
        logic [3:0] brk_addr, pc;
        logic       exp_ce;
        logic [2:0] exp_state;
        logic [7:0] exp_cycles;
    } vec_t;

    typedef struct {
        logic       ce;
        logic [2:0] state;
        logic [7:0] cycles;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    assign pc_in = use_core ? core_pc : pc_drv;

    // Minimal stand-in for the td4 core: program counter looping 0..15.
    always @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst)
            core_pc <= 4'd0;
        else if (cpu_ce)
            core_pc <= core_pc + 4'd1;
    end

    td4_run_ctrl #(.ADDR_W(4), .CNT_W(8), .MAX_CYCLES(200)) dut_a (
        .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .HALT_REQ(halt_req),
        .BRK_EN(brk_en), .BRK_ADDR(brk_addr), .PC(pc_in),
        .CPU_CE(cpu_ce), .CPU_RST(cpu_rst), .CYCLES(cycles), .STATE(state), .DONE(done)
    );

    td4_run_ctrl #(.ADDR_W(4), .CNT_W(4), .MAX_CYCLES(0)) dut_b (
        .CLK(clk), .RST(rst), .RUN(b_run), .STEP(1'b0), .HALT_REQ(1'b0),
        .BRK_EN(1'b0), .BRK_ADDR(4'd0), .PC(4'd0),
        .CPU_CE(b_ce), .CPU_RST(b_rst), .CYCLES(b_cycles), .STATE(b_state), .DONE(b_done)
    );

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic addVec(input logic r, input logic s, input logic h, input logic be,
                          input logic [3:0] ba, input logic [3:0] p,
                          input logic ce, input logic [2:0] st, input logic [7:0] cy);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.brk_en = be;
        v.brk_addr = ba; v.pc = p;
        v.exp_ce = ce; v.exp_state = st; v.exp_cycles = cy;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        run = v.run; step = v.step; halt_req = v.halt; brk_en = v.brk_en;
        brk_addr = v.brk_addr; pc_drv = v.pc;
        e.ce = v.exp_ce; e.state = v.exp_state; e.cycles = v.exp_cycles;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            checkValue($sformatf("row%0d scoreboard", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            checkValue($sformatf("row%0d ce", idx), int'(cpu_ce), int'(e.ce));
            checkValue($sformatf("row%0d state", idx), int'(state), int'(e.state));
            checkValue($sformatf("row%0d cycles", idx), int'(cycles), int'(e.cycles));
        end
    endtask

    task automatic clearInputs();
        run = 0; step = 0; halt_req = 0; brk_en = 0; brk_addr = 0; pc_drv = 0; b_run = 0;
    endtask

    // Leaves the bench at posedge+1 with CPU_RST already released.
    task automatic doReset();
        @(posedge clk); #2;
        rst = 1'b1;
        clearInputs();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ce_count;
        int k;

        use_core = 1'b0;
        rst = 1'b1;
        clearInputs();

        // Reset values on both instances
        #12;
        checkValue("reset ce", int'(cpu_ce), 0);
        checkValue("reset cpu_rst", int'(cpu_rst), 1);
        checkValue("reset cycles", int'(cycles), 0);
        checkValue("reset state", int'(state), 0);
        checkValue("reset done", int'(done), 0);
        checkValue("reset b cpu_rst", int'(b_rst), 1);
        checkValue("reset b cycles", int'(b_cycles), 0);
        rst = 1'b0;
        #1;
        checkValue("cpu_rst held after release", int'(cpu_rst), 1);
        @(posedge clk); #1;
        checkValue("cpu_rst cleared at edge", int'(cpu_rst), 0);

        // Table: run, step, halt, brk_en, brk_addr, pc | ce, state, cycles
        addVec(0,0,0,0,4'd0,4'd0, 0,3'd0,8'd0);
        addVec(0,1,0,0,4'd0,4'd0, 0,3'd0,8'd0);
        addVec(0,0,0,0,4'd0,4'd1, 1,3'd2,8'd0);
        addVec(0,0,0,0,4'd0,4'd1, 0,3'd0,8'd1);
        addVec(1,1,0,0,4'd0,4'd1, 0,3'd0,8'd1);
        addVec(1,0,0,1,4'd2,4'd2, 1,3'd1,8'd1);
        addVec(1,0,0,1,4'd2,4'd3, 1,3'd1,8'd2);
        addVec(1,0,0,1,4'd3,4'd3, 0,3'd1,8'd3);
        addVec(1,1,0,1,4'd3,4'd3, 0,3'd3,8'd3);
        addVec(1,0,0,1,4'd3,4'd3, 1,3'd2,8'd3);
        addVec(1,0,0,1,4'd3,4'd4, 0,3'd0,8'd4);
        addVec(1,0,0,1,4'd3,4'd4, 1,3'd1,8'd4);
        addVec(1,0,1,1,4'd4,4'd4, 0,3'd1,8'd5);
        addVec(1,0,1,0,4'd0,4'd4, 0,3'd0,8'd5);
        addVec(0,1,1,0,4'd0,4'd4, 0,3'd0,8'd5);
        addVec(1,0,0,0,4'd0,4'd4, 0,3'd0,8'd5);
        addVec(0,0,0,0,4'd0,4'd5, 1,3'd1,8'd5);
        addVec(0,0,0,0,4'd0,4'd6, 0,3'd0,8'd6);
        addVec(0,1,0,0,4'd0,4'd6, 0,3'd0,8'd6);
        addVec(0,1,0,0,4'd0,4'd7, 1,3'd2,8'd6);
        addVec(0,0,0,0,4'd0,4'd7, 0,3'd0,8'd7);
        addVec(1,0,0,1,4'd9,4'd9, 0,3'd0,8'd7);
        addVec(1,0,0,1,4'd9,4'd9, 1,3'd1,8'd7);
        addVec(1,0,0,1,4'd9,4'd9, 0,3'd1,8'd8);
        addVec(1,0,0,1,4'd9,4'd9, 0,3'd3,8'd8);
        addVec(0,0,0,1,4'd9,4'd9, 0,3'd3,8'd8);
        addVec(0,0,0,1,4'd9,4'd9, 0,3'd0,8'd8);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i);
            @(posedge clk); #1;
        end

        // Three step pulses spaced four cycles apart
        use_core = 1'b1;
        doReset();
        ce_count = 0;
        for (int i = 0; i < 12; i++) begin
            step = (i % 4 == 0);
            @(negedge clk);
            if (cpu_ce) ce_count++;
            if (i % 4 == 1) checkValue($sformatf("step%0d in STEP", i / 4), int'(state), 2);
            if (i % 4 == 2) checkValue($sformatf("step%0d back to IDLE", i / 4), int'(state), 0);
            @(posedge clk); #1;
        end
        step = 1'b0;
        checkValue("step ce pulses", ce_count, 3);
        checkValue("step cycles", int'(cycles), 3);

        // Breakpoint at 5 on the looping program, then resume and re-break
        doReset();
        brk_en = 1'b1; brk_addr = 4'd5; run = 1'b1;
        k = 0;
        @(negedge clk);
        while (state != 3'd3 && k < 100) begin @(negedge clk); k++; end
        checkValue("brk1 reached", int'(state), 3);
        checkValue("brk1 pc", int'(core_pc), 5);
        checkValue("brk1 ce", int'(cpu_ce), 0);
        checkValue("brk1 cycles", int'(cycles), 5);
        @(posedge clk); #1; run = 1'b0;
        @(posedge clk); #1; run = 1'b1;
        k = 0;
        @(negedge clk);
        while (core_pc != 4'd6 && k < 20) begin @(negedge clk); k++; end
        checkValue("resume passes brk", int'(core_pc), 6);
        k = 0;
        while (state != 3'd3 && k < 100) begin @(negedge clk); k++; end
        checkValue("brk2 reached", int'(state), 3);
        checkValue("brk2 pc", int'(core_pc), 5);
        checkValue("brk2 cycles", int'(cycles), 21);

        // Asynchronous reset mid-run
        doReset();
        run = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        checkValue("pre-reset ce", int'(cpu_ce), 1);
        rst = 1'b1;
        #1;
        checkValue("async rst ce", int'(cpu_ce), 0);
        checkValue("async rst cpu_rst", int'(cpu_rst), 1);
        checkValue("async rst cycles", int'(cycles), 0);
        checkValue("async rst state", int'(state), 0);
        #2;
        rst = 1'b0;
        #1;
        checkValue("cpu_rst until edge", int'(cpu_rst), 1);
        @(posedge clk); #1;
        checkValue("cpu_rst after edge", int'(cpu_rst), 0);

        // Cycle limit of 200 from a clean reset
        doReset();
        run = 1'b1;
        ce_count = 0;
        k = 0;
        @(negedge clk);
        while (!done && k < 400) begin
            if (cpu_ce) ce_count++;
            @(negedge clk);
            k++;
        end
        checkValue("limit done", int'(done), 1);
        checkValue("limit ce count", ce_count, 200);
        checkValue("limit cycles", int'(cycles), 200);
        checkValue("limit state", int'(state), 4);
        checkValue("limit core pc", int'(core_pc), 8);
        @(posedge clk); #1; run = 1'b0; step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        @(negedge clk);
        checkValue("done sticky state", int'(state), 4);
        checkValue("done sticky ce", int'(cpu_ce), 0);

        // Unlimited 4-bit counter saturates at 15
        doReset();
        b_run = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkValue("sat cycles", int'(b_cycles), 15);
        checkValue("sat done", int'(b_done), 0);
        checkValue("sat ce", int'(b_ce), 1);
        checkValue("sat state", int'(b_state), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
